// File: rtl/rst_seq_gen_pkg.sv
// Shared definitions for the board reset sequencer: state encodings and
// constant-function helpers used for counter sizing.
package rst_seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // Ceiling log2 with the same semantics as $clog2 (clog2(1) == 0).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((longint'(1) << result) < longint'(value)) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_gen_sync2.sv
// Parametrised-width two-flop synchroniser with asynchronous active-high reset.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    // Two-stage capture of the asynchronous inputs into the clk_i domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/rst_seq_gen.sv
// Board-level reset sequencer: holds NCH reset channels through a cold
// period, releases them in order gated by per-channel ready inputs, and
// re-asserts on soft-reset requests or ready faults. Also generates a
// free-running one-cycle clock-enable pulse every CE_DIV cycles.
module rst_seq_gen
    import rst_seq_gen_pkg::*;
#(
    parameter int unsigned NCH          = 3,
    parameter int unsigned COLD_CYCLES  = 16384,
    parameter int unsigned STAGE_CYCLES = 256,
    parameter int unsigned CE_DIV       = 2,
    parameter int unsigned FAULT_ALL    = 1
) (
    input  logic                       clk100,
    input  logic                       sys_rst,
    input  logic                       req_rst,
    input  logic [NCH-1:0]             ready_in,
    output logic [NCH-1:0]             rst_out,
    output logic                       ce_out,
    output logic                       busy,
    output logic [$clog2(NCH+1)-1:0]   stage_idx
);

    localparam int unsigned IDX_W = clog2(NCH + 1);
    localparam int unsigned CNT_W = clog2(max2(COLD_CYCLES, STAGE_CYCLES) + 1);
    localparam int unsigned CE_W  = clog2(CE_DIV);

    localparam logic [CNT_W-1:0] COLD_LAST  = CNT_W'(COLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CE_W-1:0]  CE_LAST    = CE_W'(CE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NCH - 1);

    // Synchronised inputs
    logic [NCH:0]     sync_w;
    logic             rs;
    logic [NCH-1:0]   rdy_s;

    // Sequencer state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NCH-1:0]   rst_q, rst_d;
    logic             busy_q, busy_d;

    // Clock-enable generator
    logic [CE_W-1:0]  ce_cnt_q, ce_cnt_d;
    logic             ce_q, ce_d;

    // Fault detection / current channel readiness
    logic             fault;
    logic [IDX_W-1:0] fault_j;
    logic             cur_rdy;

    sync2 #(
        .W(NCH + 1)
    ) u_sync (
        .clk_i (clk100),
        .rst_i (sys_rst),
        .d_i   ({req_rst, ready_in}),
        .q_o   (sync_w)
    );

    assign rs    = sync_w[NCH];
    assign rdy_s = sync_w[NCH-1:0];

    // Lowest already-released channel whose ready has dropped, and the
    // synchronised ready of the channel currently awaiting release.
    always_comb begin
        fault   = 1'b0;
        fault_j = '0;
        cur_rdy = 1'b0;
        for (int unsigned j = 0; j < NCH; j++) begin
            if (!fault && (IDX_W'(j) < idx_q) && !rdy_s[j]) begin
                fault   = 1'b1;
                fault_j = IDX_W'(j);
            end
            if (IDX_W'(j) == idx_q) begin
                cur_rdy = rdy_s[j];
            end
        end
    end

    // Next-state logic: soft request beats fault, fault beats normal release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;

        if (state_q == ST_HOLD) begin
            rst_d = '1;
            if (rs) begin
                cnt_d = '0;
            end else if (cnt_q == COLD_LAST) begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
                idx_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (rs || (fault && (FAULT_ALL != 0))) begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
                rst_d   = '1;
            end else if (fault) begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
                idx_d   = fault_j;
                for (int unsigned k = 0; k < NCH; k++) begin
                    if (IDX_W'(k) >= fault_j) begin
                        rst_d[k] = 1'b1;
                    end
                end
            end else if (state_q == ST_RELEASE) begin
                if (cnt_q == STAGE_LAST) begin
                    if (cur_rdy) begin
                        for (int unsigned k = 0; k < NCH; k++) begin
                            if (IDX_W'(k) == idx_q) begin
                                rst_d[k] = 1'b0;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        busy_d = |rst_d;
    end

    // Sequencer registers; every output comes straight from a flop.
    always_ff @(posedge clk100 or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
        end
    end

    // Free-running divider; pulse is registered alongside the count it reflects.
    always_comb begin
        ce_cnt_d = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + 1'b1;
        ce_d     = (ce_cnt_d == CE_LAST);
    end

    // Clock-enable registers, cleared only by the board reset.
    always_ff @(posedge clk100 or posedge sys_rst) begin
        if (sys_rst) begin
            ce_cnt_q <= '0;
            ce_q     <= 1'b0;
        end else begin
            ce_cnt_q <= ce_cnt_d;
            ce_q     <= ce_d;
        end
    end

    assign rst_out   = rst_q;
    assign busy      = busy_q;
    assign stage_idx = idx_q;
    assign ce_out    = ce_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: two instances (full-restart and partial
// fault modes) share one clock; expected output snapshots are queued as
// stimulus is applied and compared when their edge arrives.
module tb_rst_seq_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, req_a, req_b;
    logic [2:0] rdy_a, rdy_b;
    logic [2:0] ro_a, ro_b;
    logic       ce_a, ce_b, busy_a, busy_b;
    logic [1:0] idx_a, idx_b;

    rst_seq_gen #(
        .NCH(3), .COLD_CYCLES(16), .STAGE_CYCLES(4), .CE_DIV(2), .FAULT_ALL(1)
    ) dut_a (
        .clk100(clk), .sys_rst(rst_a), .req_rst(req_a), .ready_in(rdy_a),
        .rst_out(ro_a), .ce_out(ce_a), .busy(busy_a), .stage_idx(idx_a)
    );

    rst_seq_gen #(
        .NCH(3), .COLD_CYCLES(16), .STAGE_CYCLES(4), .CE_DIV(5), .FAULT_ALL(0)
    ) dut_b (
        .clk100(clk), .sys_rst(rst_b), .req_rst(req_b), .ready_in(rdy_b),
        .rst_out(ro_b), .ce_out(ce_b), .busy(busy_b), .stage_idx(idx_b)
    );

    typedef struct {
        int unsigned which;
        int unsigned at;
        logic [2:0]  rst;
        logic        busy;
        logic [1:0]  idx;
        logic        ce;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    int unsigned base_b;

    // Queue an expected snapshot; ce is derived from the instance's divider
    // and the edge count since its last reset release.
    task automatic expect_at(input int unsigned which, input int unsigned at,
                             input logic [2:0] r, input logic b, input logic [1:0] ix,
                             input bit in_rst, input string tag);
        exp_t        e;
        int unsigned div;
        int unsigned base;
        div    = (which == 0) ? 2 : 5;
        base   = (which == 0) ? 0 : base_b;
        e.which = which;
        e.at    = at;
        e.rst   = r;
        e.busy  = b;
        e.idx   = ix;
        e.ce    = in_rst ? 1'b0 : (((at - base) % div) == (div - 1));
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field, input logic [2:0] obs,
                       input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s cyc=%0d got=%b expected=%b", tag, field, cyc, obs, exp);
        end
    endtask

    task automatic check_due();
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].at < cyc) begin
                checks++;
                errors++;
                $error("FAIL %s.late cyc=%0d got=missed expected=at %0d", sb[i].tag, cyc, sb[i].at);
                sb.delete(i);
            end else if (sb[i].at == cyc) begin
                if (sb[i].which == 0) begin
                    cmp(sb[i].tag, "rst", ro_a, sb[i].rst);
                    cmp(sb[i].tag, "busy", {2'b00, busy_a}, {2'b00, sb[i].busy});
                    cmp(sb[i].tag, "idx", {1'b0, idx_a}, {1'b0, sb[i].idx});
                    cmp(sb[i].tag, "ce", {2'b00, ce_a}, {2'b00, sb[i].ce});
                end else begin
                    cmp(sb[i].tag, "rst", ro_b, sb[i].rst);
                    cmp(sb[i].tag, "busy", {2'b00, busy_b}, {2'b00, sb[i].busy});
                    cmp(sb[i].tag, "idx", {1'b0, idx_b}, {1'b0, sb[i].idx});
                    cmp(sb[i].tag, "ce", {2'b00, ce_b}, {2'b00, sb[i].ce});
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        base_b = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        rdy_a  = 3'b111;
        rdy_b  = 3'b101;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        expect_at(0, 0, 3'b111, 1'b1, 2'd0, 1'b1, "reset_a");
        expect_at(1, 0, 3'b111, 1'b1, 2'd0, 1'b1, "reset_b");
        check_due();
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // A: ordered release at 20/24/28; B: channel 1 gated until ready at edge 40
        expect_at(0, 19, 3'b111, 1'b1, 2'd0, 1'b0, "a_pre0");
        expect_at(0, 20, 3'b110, 1'b1, 2'd1, 1'b0, "a_rel0");
        expect_at(0, 23, 3'b110, 1'b1, 2'd1, 1'b0, "a_pre1");
        expect_at(0, 24, 3'b100, 1'b1, 2'd2, 1'b0, "a_rel1");
        expect_at(0, 27, 3'b100, 1'b1, 2'd2, 1'b0, "a_pre2");
        expect_at(0, 28, 3'b000, 1'b0, 2'd3, 1'b0, "a_rel2");
        expect_at(1, 20, 3'b110, 1'b1, 2'd1, 1'b0, "b_rel0");
        expect_at(1, 41, 3'b110, 1'b1, 2'd1, 1'b0, "b_wait1");
        expect_at(1, 42, 3'b100, 1'b1, 2'd2, 1'b0, "b_rel1");
        expect_at(1, 45, 3'b100, 1'b1, 2'd2, 1'b0, "b_pre2");
        expect_at(1, 46, 3'b000, 1'b0, 2'd3, 1'b0, "b_rel2");
        while (cyc < 50) begin
            step();
            if (cyc == 39) rdy_b[1] = 1'b1;
        end

        // A: one-cycle soft request; B: partial fault on channel 1 for 10 cycles
        expect_at(0, 52, 3'b000, 1'b0, 2'd3, 1'b0, "a_req_pre");
        expect_at(0, 53, 3'b111, 1'b1, 2'd0, 1'b0, "a_req_hit");
        expect_at(0, 72, 3'b111, 1'b1, 2'd0, 1'b0, "a_rr_pre0");
        expect_at(0, 73, 3'b110, 1'b1, 2'd1, 1'b0, "a_rr_rel0");
        expect_at(0, 76, 3'b110, 1'b1, 2'd1, 1'b0, "a_rr_pre1");
        expect_at(0, 77, 3'b100, 1'b1, 2'd2, 1'b0, "a_rr_rel1");
        expect_at(0, 80, 3'b100, 1'b1, 2'd2, 1'b0, "a_rr_pre2");
        expect_at(0, 81, 3'b000, 1'b0, 2'd3, 1'b0, "a_rr_rel2");
        expect_at(1, 52, 3'b000, 1'b0, 2'd3, 1'b0, "b_flt_pre");
        expect_at(1, 53, 3'b110, 1'b1, 2'd1, 1'b0, "b_flt_hit");
        expect_at(1, 62, 3'b110, 1'b1, 2'd1, 1'b0, "b_flt_wait");
        expect_at(1, 63, 3'b100, 1'b1, 2'd2, 1'b0, "b_flt_rel1");
        expect_at(1, 66, 3'b100, 1'b1, 2'd2, 1'b0, "b_flt_pre2");
        expect_at(1, 67, 3'b000, 1'b0, 2'd3, 1'b0, "b_flt_rel2");
        req_a    = 1'b1;
        rdy_b[1] = 1'b0;
        while (cyc < 70) begin
            step();
            if (cyc == 51) req_a = 1'b0;
            if (cyc == 60) rdy_b[1] = 1'b1;
        end

        // B: simultaneous faults plus soft request; request wins, cold hold frozen while held
        expect_at(1, 72, 3'b000, 1'b0, 2'd3, 1'b0, "b_prio_pre");
        expect_at(1, 73, 3'b111, 1'b1, 2'd0, 1'b0, "b_prio_hit");
        expect_at(1, 78, 3'b111, 1'b1, 2'd0, 1'b0, "b_prio_hold");
        expect_at(1, 101, 3'b111, 1'b1, 2'd0, 1'b0, "b_prio_pre0");
        expect_at(1, 102, 3'b110, 1'b1, 2'd1, 1'b0, "b_prio_rel0");
        expect_at(1, 105, 3'b110, 1'b1, 2'd1, 1'b0, "b_prio_pre1");
        expect_at(1, 106, 3'b100, 1'b1, 2'd2, 1'b0, "b_prio_rel1");
        expect_at(1, 109, 3'b100, 1'b1, 2'd2, 1'b0, "b_prio_pre2");
        expect_at(1, 110, 3'b000, 1'b0, 2'd3, 1'b0, "b_prio_rel2");
        rdy_b = 3'b001;
        req_b = 1'b1;
        while (cyc < 110) begin
            step();
            if (cyc == 80) begin
                req_b = 1'b0;
                rdy_b = 3'b111;
            end
        end

        // B: clock-enable every 5 cycles, then async board reset while ce is high
        for (int unsigned c = 111; c <= 124; c++) begin
            expect_at(1, c, 3'b000, 1'b0, 2'd3, 1'b0, "b_ce_run");
        end
        while (cyc < 124) step();
        #2;
        rst_b = 1'b1;
        #1;
        expect_at(1, cyc, 3'b111, 1'b1, 2'd0, 1'b1, "b_async_rst");
        check_due();
        @(negedge clk);
        rst_b  = 1'b0;
        base_b = cyc;
        for (int unsigned c = 125; c <= 134; c++) begin
            expect_at(1, c, 3'b111, 1'b1, 2'd0, 1'b0, "b_ce_restart");
        end
        while (cyc < 134) step();

        // Anything still queued was never compared
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $error("FAIL %s.unchecked got=none expected=at %0d", e.tag, e.at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
